// File: rtl/m_scroll_ctrl.sv
// m_scroll_ctrl
//   Scrolls a 16-character message from an external ROM across a 4-digit
//   7-segment display. A 4-character window is loaded from the ROM, advanced
//   one character per scroll tick, and time-multiplexed onto a shared
//   active-low segment bus.
//
// Ports
//   clk      in   1   system clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   tick     in   1   scroll enable pulse (1 cycle)
//   run      in   1   1 = scroll on tick, 0 = freeze window
//   sw       in   1   raw message-select switch (asynchronous)
//   rom_dat  in   8   ROM character, active-low segments {dp,g..a}
//   rom_adr  out  4   ROM address (character pointer)
//   rom_sw   out  1   ROM message select (synchronized sw, latched at restart)
//   disp     out  32  window; [31:24] leftmost digit 3 .. [7:0] rightmost digit 0
//   an       out  4   active-low one-hot digit enables; an[i] selects disp byte i
//   seg      out  8   active-low segment bus for the enabled digit
//   busy     out  1   high whenever the sequencer is not idling in RUN
module m_scroll_ctrl #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        run,
  input  logic        sw,
  input  logic [7:0]  rom_dat,
  output logic [3:0]  rom_adr,
  output logic        rom_sw,
  output logic [31:0] disp,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        busy
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [1:0]  fill_cnt_q, fill_cnt_d;
  logic [31:0] disp_q, disp_d;
  logic        rom_sw_q, rom_sw_d;
  logic        busy_q, busy_d;

  logic        sw_meta_q, sw_s_q;
  logic        restart;

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  an_q, an_d;
  logic [7:0]  seg_q, seg_d;

  // Two-flop synchronizer for the switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= 1'b0;
      sw_s_q    <= 1'b0;
    end else begin
      sw_meta_q <= sw;
      sw_s_q    <= sw_meta_q;
    end
  end

  // A change of the selected message restarts the fill from character 0.
  assign restart = (sw_s_q != rom_sw_q);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    fill_cnt_d = fill_cnt_q;
    disp_d     = disp_q;
    rom_sw_d   = rom_sw_q;

    if (restart) begin
      rom_sw_d   = sw_s_q;
      ptr_d      = '0;
      disp_d     = '1;
      fill_cnt_d = '0;
      state_d    = FILL;
    end else begin
      case (state_q)
        FILL: begin
          disp_d     = {disp_q[23:0], rom_dat};
          ptr_d      = ptr_q + 4'd1;
          fill_cnt_d = fill_cnt_q + 2'd1;
          if (fill_cnt_q == 2'd3) begin
            state_d = RUN;
          end
        end
        RUN: begin
          // Ticks arriving in any other state or with run low are dropped.
          if (run && tick) begin
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          disp_d  = {disp_q[23:0], rom_dat};
          ptr_d   = ptr_q + 4'd1;
          state_d = RUN;
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end

    // Registered from the next state so busy falls in the first RUN cycle.
    busy_d = (state_d != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      ptr_q      <= '0;
      fill_cnt_q <= '0;
      disp_q     <= '1;
      rom_sw_q   <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      fill_cnt_q <= fill_cnt_d;
      disp_q     <= disp_d;
      rom_sw_q   <= rom_sw_d;
      busy_q     <= busy_d;
    end
  end

  // Digit scan, free-running and independent of the sequencer.
  always_comb begin
    if (cnt_q == SCAN_DIV - 16'd1) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 16'd1;
      idx_d = idx_q;
    end

    an_d = ~(4'b0001 << idx_q);

    case (idx_q)
      2'd0:    seg_d = disp_q[7:0];
      2'd1:    seg_d = disp_q[15:8];
      2'd2:    seg_d = disp_q[23:16];
      default: seg_d = disp_q[31:24];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= '1;
      seg_q <= '1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign rom_adr = ptr_q;
  assign rom_sw  = rom_sw_q;
  assign disp    = disp_q;
  assign an      = an_q;
  assign seg     = seg_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_m_scroll_ctrl.sv
module tb_m_scroll_ctrl;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        run;
  logic        sw;
  logic [7:0]  rom_dat;
  logic [3:0]  rom_adr;
  logic        rom_sw;
  logic [31:0] disp;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        busy;

  logic [7:0]  rom [0:31];

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  adr;
    logic        bsy;
    logic        rsw;
  } win_t;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
  } scan_t;

  win_t  exp_q [$];
  scan_t scan_q [$];

  int errors = 0;
  int checks = 0;

  m_scroll_ctrl #(.SCAN_DIV(16'd4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .run     (run),
    .sw      (sw),
    .rom_dat (rom_dat),
    .rom_adr (rom_adr),
    .rom_sw  (rom_sw),
    .disp    (disp),
    .an      (an),
    .seg     (seg),
    .busy    (busy)
  );

  // External message ROM model.
  assign rom_dat = rom[{rom_sw, rom_adr}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] win(input logic m, input int n);
    logic [3:0]  a;
    logic [31:0] w;
    a = n[3:0];
    w = '0;
    for (int i = 0; i < 4; i++) begin
      w = {w[23:0], rom[{m, a}]};
      a = a + 4'd1;
    end
    return w;
  endfunction

  task automatic push_restart(input logic m);
    win_t e;
    e.d = '1; e.adr = 4'd0; e.bsy = 1'b1; e.rsw = m;
    exp_q.push_back(e);
  endtask

  task automatic push_fill(input logic m);
    win_t        e;
    logic [31:0] d;
    logic [3:0]  a;
    d = '1;
    for (int k = 0; k < 4; k++) begin
      a   = k[3:0];
      d   = {d[23:0], rom[{m, a}]};
      e.d = d; e.adr = a + 4'd1; e.bsy = (k != 3); e.rsw = m;
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  // Monitor: every window change is popped and compared; scan entries are
  // compared once per cycle while queued.
  initial begin
    logic [31:0] prev;
    win_t        e;
    scan_t       s;
    prev = '1;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev = disp;
      end else begin
        if (disp !== prev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_window", {8'h0, disp}, {8'h0, prev});
          end else begin
            e = exp_q.pop_front();
            chk("window", {2'b0, disp, rom_adr, busy, rom_sw},
                          {2'b0, e.d, e.adr, e.bsy, e.rsw});
          end
        end
        prev = disp;
      end
      if (scan_q.size() > 0) begin
        s = scan_q.pop_front();
        chk("scan", {28'h0, an, seg}, {28'h0, s.an, s.seg});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int    k;
    win_t  e;
    scan_t s;

    rom[0]  = 8'h89; rom[1]  = 8'h86; rom[2]  = 8'hC7; rom[3]  = 8'hC7;
    rom[4]  = 8'hC0; rom[5]  = 8'hFF; rom[6]  = 8'h92; rom[7]  = 8'h88;
    rom[8]  = 8'hA1; rom[9]  = 8'hF9; rom[10] = 8'hA4; rom[11] = 8'hB0;
    rom[12] = 8'h99; rom[13] = 8'h92; rom[14] = 8'h82; rom[15] = 8'hF8;
    rom[16] = 8'hC2; rom[17] = 8'hC0; rom[18] = 8'hC0; rom[19] = 8'hA1;
    for (int i = 20; i < 32; i++) rom[i] = 8'hBF;

    rst_n = 1'b0; tick = 1'b0; run = 1'b0; sw = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_disp", {8'h0, disp}, 40'hFFFF_FFFF);
    chk("rst_adr",  {36'h0, rom_adr}, 40'h0);
    chk("rst_romsw_busy", {38'h0, rom_sw, busy}, 40'h1);
    chk("rst_an_seg", {28'h0, an, seg}, {28'h0, 4'hF, 8'hFF});

    // T1: initial fill
    push_fill(1'b0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("fill_busy", {39'h0, busy}, 40'h1);
    @(negedge clk);
    chk("t1_busy", {39'h0, busy}, 40'h0);
    chk("t1_disp", {8'h0, disp}, 40'h8986_C7C7);
    chk("t1_adr",  {36'h0, rom_adr}, 40'h4);

    // T2: 16 ticks wrap back to the initial window
    run = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      e.d = win(1'b0, n); e.adr = 4'(n + 4); e.bsy = 1'b0; e.rsw = 1'b0;
      exp_q.push_back(e);
      pulse_tick();
      if (n == 1) begin
        chk("t2_shift_busy", {39'h0, busy}, 40'h1);
        chk("t2_shift_hold", {8'h0, disp}, 40'h8986_C7C7);
      end
      @(negedge clk);
      if (n == 1) chk("t2_ello", {8'h0, disp}, 40'h86C7_C7C0);
      repeat (2) @(negedge clk);
    end
    chk("t2_wrap_disp", {8'h0, disp}, 40'h8986_C7C7);
    chk("t2_wrap_adr",  {36'h0, rom_adr}, 40'h4);

    // T3: message switch restarts the fill
    push_restart(1'b1);
    push_fill(1'b1);
    sw = 1'b1;
    repeat (3) @(negedge clk);
    chk("t3_clear", {7'h0, disp, busy}, {7'h0, 32'hFFFF_FFFF, 1'b1});
    chk("t3_clear_adr", {36'h0, rom_adr}, 40'h0);
    repeat (4) @(negedge clk);
    chk("t3_good", {6'h0, disp, rom_sw, busy}, {6'h0, 32'hC2C0_C0A1, 1'b1, 1'b0});

    // T4a: frozen window ignores ticks
    run = 1'b0;
    repeat (5) begin
      pulse_tick();
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("t4_frozen", {8'h0, disp}, 40'hC2C0_C0A1);

    // T4b: tick during the second fill cycle is dropped
    run = 1'b1;
    push_restart(1'b0);
    push_fill(1'b0);
    sw = 1'b0;
    repeat (4) @(negedge clk);
    tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_fill_done", {3'h0, disp, rom_adr, busy}, {3'h0, 32'h8986_C7C7, 4'h4, 1'b0});
    repeat (4) @(negedge clk);
    chk("t4_no_shift", {8'h0, disp}, 40'h8986_C7C7);

    // T5: digit scan
    k = 0;
    while (an == 4'b1110 && k < 20) begin @(negedge clk); k++; end
    k = 0;
    while (an != 4'b1110 && k < 20) begin @(negedge clk); k++; end
    chk("scan_sync", {36'h0, an}, 40'hE);
    for (int i = 0; i < 15; i++) begin
      case ((i + 1) / 4)
        0:       begin s.an = 4'b1110; s.seg = 8'hC7; end
        1:       begin s.an = 4'b1101; s.seg = 8'hC7; end
        2:       begin s.an = 4'b1011; s.seg = 8'h86; end
        default: begin s.an = 4'b0111; s.seg = 8'h89; end
      endcase
      scan_q.push_back(s);
    end
    repeat (17) @(negedge clk);

    // T6: asynchronous reset in the middle of a shift
    pulse_tick();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_an_seg", {28'h0, an, seg}, {28'h0, 4'hF, 8'hFF});
    chk("t6_disp", {8'h0, disp}, 40'hFFFF_FFFF);
    chk("t6_adr_busy", {35'h0, rom_adr, busy}, {35'h0, 4'h0, 1'b1});
    push_fill(1'b0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_refill", {3'h0, disp, rom_adr, busy}, {3'h0, 32'h8986_C7C7, 4'h4, 1'b0});

    repeat (10) @(negedge clk);
    chk("exp_q_drained",  40'(exp_q.size()), 40'h0);
    chk("scan_q_drained", 40'(scan_q.size()), 40'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
